// File: rtl/invaders_video_pkg.sv
// Shared types and constants for the Midway-Taito 8080 video fetch path.
// The colour fetch states are used only when INVADERS_COLOR_RAM_EN is defined.
package invaders_video_pkg;

    localparam int DEF_H_TOTAL  = 320;
    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_HS_START = 272;
    localparam int DEF_HS_END   = 304;
    localparam int DEF_V_TOTAL  = 262;
    localparam int DEF_V_ACTIVE = 224;
    localparam int DEF_VS_START = 236;
    localparam int DEF_VS_END   = 240;

    localparam logic [15:0] VRAM_BASE   = 16'h2400;
    localparam logic [15:0] COLRAM_BASE = 16'hC400;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CAPT  = 3'd2,
        CADDR = 3'd3,
        CCAPT = 3'd4
    } fetch_state_t;

    // 32 bytes per line, one byte per 8-pixel column
    function automatic logic [15:0] vram_addr(input logic [7:0] line, input logic [4:0] col);
        return VRAM_BASE + {3'b000, line, col};
    endfunction

    // Colour RAM is shared by each band of 8 lines
    function automatic logic [15:0] colram_addr(input logic [4:0] band, input logic [4:0] col);
        return COLRAM_BASE + {6'b000000, band, col};
    endfunction

endpackage

// File: rtl/invaders_raster_cnt.sv
// Raster counters plus registered sync/blank decode; exposes next-count values
// so the fetch logic can act in the same PixEn edge the counters move.
module invaders_raster_cnt
    import invaders_video_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pix_en_i,
    output logic [8:0] hcnt_nxt_o,
    output logic [8:0] vcnt_nxt_o,
    output logic       hblank_nxt_o,
    output logic       vblank_nxt_o,
    output logic [7:0] line_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       hblank_o,
    output logic       vblank_o
);

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       hsync_q, vsync_q, hblank_q, vblank_q;

    always_comb begin
        hcnt_d = hcnt_q + 9'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == 9'(H_TOTAL - 1)) begin
            hcnt_d = 9'd0;
            if (vcnt_q == 9'(V_TOTAL - 1)) begin
                vcnt_d = 9'd0;
            end else begin
                vcnt_d = vcnt_q + 9'd1;
            end
        end else begin
            hcnt_d = hcnt_q + 9'd1;
        end
    end

    // Decode is taken from the next count so it lines up with the registered pixel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcnt_q   <= 9'd0;
            vcnt_q   <= 9'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
        end else if (pix_en_i) begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hsync_q  <= (hcnt_d >= 9'(HS_START)) && (hcnt_d < 9'(HS_END));
            vsync_q  <= (vcnt_d >= 9'(VS_START)) && (vcnt_d < 9'(VS_END));
            hblank_q <= hblank_nxt_o;
            vblank_q <= vblank_nxt_o;
        end
    end

    assign hcnt_nxt_o   = hcnt_d;
    assign vcnt_nxt_o   = vcnt_d;
    assign hblank_nxt_o = (hcnt_d >= 9'(H_ACTIVE));
    assign vblank_nxt_o = (vcnt_d >= 9'(V_ACTIVE));
    assign line_o       = vcnt_q[7:0];
    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign hblank_o     = hblank_q;
    assign vblank_o     = vblank_q;

endmodule

// File: rtl/invaders_video_fetch.sv
// Video RAM fetch and 1bpp serialiser for the Midway-Taito 8080 boards.
// Define INVADERS_COLOR_RAM_EN to add a colour RAM read after each pixel byte.
module invaders_video_fetch
    import invaders_video_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PixEn,
    output logic [15:0] Ram_Addr,
    input  logic [7:0]  Ram_out,
    output logic        Rd_req,
    output logic        Video,
    output logic [2:0]  Color,
    output logic        HSync,
    output logic        VSync,
    output logic        HBlank,
    output logic        VBlank,
    output logic [7:0]  Line
);

    logic [8:0]   hcnt_nxt_s, vcnt_nxt_s;
    logic         hblank_nxt_s, vblank_nxt_s;
    fetch_state_t state_q, state_d;
    logic [15:0]  ram_addr_q, ram_addr_d;
    logic         rd_req_q, rd_req_d;
    logic [7:0]   hold_q, sr_q, sr_d;
    logic         video_q, video_d;
    logic [2:0]   color_q, color_d;
    logic         armed_q;
    logic         trig_s, arm_s, fetch_go_s, load_s;
    logic [4:0]   trig_col_s;
    logic [8:0]   trig_line_s;
`ifdef INVADERS_COLOR_RAM_EN
    logic [4:0]   col_q, band_q;
    logic [2:0]   col_hold_q;
`endif

    invaders_raster_cnt #(
        .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START), .HS_END(HS_END),
        .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_END(VS_END)
    ) u_raster (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .pix_en_i    (PixEn),
        .hcnt_nxt_o  (hcnt_nxt_s),
        .vcnt_nxt_o  (vcnt_nxt_s),
        .hblank_nxt_o(hblank_nxt_s),
        .vblank_nxt_o(vblank_nxt_s),
        .line_o      (Line),
        .hsync_o     (HSync),
        .vsync_o     (VSync),
        .hblank_o    (HBlank),
        .vblank_o    (VBlank)
    );

    // Column 0 is fetched at the end of the previous line; the wrap into line 0 arms fetching
    always_comb begin
        trig_col_s  = hcnt_nxt_s[7:3] + 5'd1;
        trig_line_s = vcnt_nxt_s;
        arm_s       = 1'b0;
        if (hcnt_nxt_s == 9'(H_TOTAL - 2)) begin
            trig_s     = 1'b1;
            trig_col_s = 5'd0;
            if (vcnt_nxt_s == 9'(V_TOTAL - 1)) begin
                trig_line_s = 9'd0;
                arm_s       = 1'b1;
            end else begin
                trig_line_s = vcnt_nxt_s + 9'd1;
            end
        end else if ((hcnt_nxt_s[2:0] == 3'd6) && (hcnt_nxt_s < 9'(H_ACTIVE - 8))) begin
            trig_s = 1'b1;
        end else begin
            trig_s = 1'b0;
        end
        fetch_go_s = PixEn && trig_s && (armed_q || arm_s) && (trig_line_s < 9'(V_ACTIVE));
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fetch_go_s) begin
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: state_d = CAPT;
`ifdef INVADERS_COLOR_RAM_EN
            CAPT:  state_d = CADDR;
`else
            CAPT:  state_d = IDLE;
`endif
            CADDR: state_d = CCAPT;
            CCAPT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read port outputs are decoded from the next state so they register with it
    always_comb begin
        rd_req_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        case (state_d)
            ADDR: begin
                rd_req_d   = 1'b1;
                ram_addr_d = vram_addr(trig_line_s[7:0], trig_col_s);
            end
`ifdef INVADERS_COLOR_RAM_EN
            CADDR: begin
                rd_req_d   = 1'b1;
                ram_addr_d = colram_addr(band_q, col_q);
            end
`endif
            default: begin
                rd_req_d   = 1'b0;
                ram_addr_d = ram_addr_q;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_req_q   <= 1'b0;
            ram_addr_q <= VRAM_BASE;
            hold_q     <= 8'h00;
            armed_q    <= 1'b0;
        end else begin
            rd_req_q   <= rd_req_d;
            ram_addr_q <= ram_addr_d;
            if (state_q == CAPT) begin
                hold_q <= Ram_out;
            end
            if (PixEn && arm_s) begin
                armed_q <= 1'b1;
            end
        end
    end

`ifdef INVADERS_COLOR_RAM_EN
    // Colour read needs the column and line band of the byte just fetched
    always_ff @(posedge Clock) begin
        if (Reset) begin
            col_q      <= 5'd0;
            band_q     <= 5'd0;
            col_hold_q <= 3'b000;
        end else begin
            if (fetch_go_s && (state_q == IDLE)) begin
                col_q  <= trig_col_s;
                band_q <= trig_line_s[7:3];
            end
            if (state_q == CCAPT) begin
                col_hold_q <= Ram_out[2:0];
            end
        end
    end
`endif

    always_comb begin
        load_s  = (hcnt_nxt_s[2:0] == 3'd0) && (hcnt_nxt_s < 9'(H_ACTIVE));
        sr_d    = load_s ? hold_q : {1'b0, sr_q[7:1]};
        video_d = sr_d[0] & ~hblank_nxt_s & ~vblank_nxt_s;
`ifdef INVADERS_COLOR_RAM_EN
        color_d = load_s ? col_hold_q : color_q;
`else
        color_d = video_d ? 3'b111 : 3'b000;
`endif
    end

    // Serialiser: LSB is the leftmost pixel of each byte
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sr_q    <= 8'h00;
            video_q <= 1'b0;
            color_q <= 3'b000;
        end else if (PixEn) begin
            sr_q    <= sr_d;
            video_q <= video_d;
            color_q <= color_d;
        end
    end

    assign Ram_Addr = ram_addr_q;
    assign Rd_req   = rd_req_q;
    assign Video    = video_q;
    assign Color    = color_q;

endmodule
